// File: rtl/fetch_unit.sv
// RV32 instruction fetch: owns the PC, keeps at most one word fetch in flight,
// and buffers {pc, word} pairs toward decode; redirects flush and squash.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [24:0] instruction
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [29:0] pc_word;
        logic [31:0] word;
    } fifo_entry_t;

    logic [29:0]      r_pc_word;
    logic [29:0]      r_req_pc_word;
    logic             r_outstanding;
    logic             r_stale;
    fifo_entry_t      r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_has_room;
    logic             w_grant;
    logic             w_push;
    logic             w_pop;
    fifo_entry_t      w_head;
    logic             w_unused_bits;

    // Room is reserved at issue: only one fetch in flight and only when a slot is free.
    assign w_has_room    = r_count < CNT_W'(FIFO_DEPTH);
    assign imem_req      = !rst && !r_outstanding && !redirect_valid && w_has_room;
    assign imem_addr     = {r_pc_word, 2'b00};
    assign w_grant       = imem_req && imem_gnt;
    assign w_push        = imem_rvalid && !r_stale && !redirect_valid;

    assign inst_valid    = !rst && (r_count != '0) && !redirect_valid;
    assign w_pop         = inst_valid && inst_ready;
    assign w_head        = r_fifo[r_rd_ptr];
    assign inst_pc       = {w_head.pc_word, 2'b00};
    assign opcode        = w_head.word[6:0];
    assign instruction   = w_head.word[31:7];

    assign w_unused_bits = ^{redirect_pc[1:0], RESET_PC[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_word     <= RESET_PC[31:2];
            r_req_pc_word <= '0;
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (redirect_valid) begin
            // A response landing in the redirect cycle is simply dropped; otherwise
            // the single in-flight response is marked for discard.
            r_pc_word <= redirect_pc[31:2];
            r_stale   <= r_outstanding && !imem_rvalid;
            if (imem_rvalid) begin
                r_outstanding <= 1'b0;
            end
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (imem_rvalid) begin
                r_outstanding <= 1'b0;
                r_stale       <= 1'b0;
            end
            if (w_grant) begin
                r_outstanding <= 1'b1;
                r_req_pc_word <= r_pc_word;
                r_pc_word     <= r_pc_word + 30'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo[r_wr_ptr] <= {r_req_pc_word, imem_rdata};
        end
    end

endmodule
